// File: rtl/tiny_cpu_param.sv
// tiny_cpu_param: parametrised TinyCPU datapath with an NREG-entry register file, a single-cycle ALU,
// registered Result/{N,C,Z} flags and a multi-cycle shift-add MUL that back-pressures the source.
module tiny_cpu_param #(
  parameter  int DATA_W  = 8,
  parameter  int NREG    = 4,
  localparam int RA_W    = $clog2(NREG),
  localparam int INSTR_W = 4 + 2*RA_W + DATA_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] In,
  input  logic               InValid,
  output logic               InReady,
  output logic [DATA_W-1:0]  Result,
  output logic [2:0]         Flags,
  output logic               Done,
  output logic               IllegalOp,
  input  logic [RA_W-1:0]    DbgSel,
  output logic [DATA_W-1:0]  DbgData
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [3:0] {
    OP_CLR = 4'h0, OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3,
    OP_SUB = 4'h4, OP_XOR = 4'h5, OP_AND = 4'h6, OP_SHR = 4'h7,
    OP_SHL = 4'h8, OP_CMP = 4'h9, OP_MUL = 4'hA
  } op_e;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  logic [3:0]          op;
  logic [RA_W-1:0]     rd, rs;
  logic [DATA_W-1:0]   imm, a, b;
  logic [DATA_W-1:0]   regs [NREG];
  logic [DATA_W-1:0]   result_q;
  logic [2:0]          flags_q;
  logic                done_q, illegal_q;
  state_e              state, state_nxt;
  logic                accept, mul_last;
  logic [2*DATA_W-1:0] mcand, acc, acc_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;

  logic [DATA_W-1:0]   alu_res, wr_val;
  logic [2:0]          alu_flags;
  logic [DATA_W:0]     ext;
  logic                upd, wr_reg, clr_all, illegal;

  assign op  = In[INSTR_W-1 -: 4];
  assign rd  = In[DATA_W+2*RA_W-1 -: RA_W];
  assign rs  = In[DATA_W+RA_W-1 -: RA_W];
  assign imm = In[DATA_W-1:0];
  assign a   = regs[rd];
  assign b   = regs[rs];

  assign accept   = InValid & InReady;
  assign mul_last = (state == ST_MUL) && (cnt == CNT_W'(DATA_W-1));
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

  function automatic logic [2:0] nzc(input logic [DATA_W-1:0] v, input logic c);
    return {v[DATA_W-1], c, v == '0};
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && op == OP_MUL) state_nxt = ST_MUL;
      ST_MUL:  if (mul_last)               state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    InReady = (state == ST_IDLE);
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    alu_res   = result_q;
    alu_flags = flags_q;
    ext       = '0;
    wr_val    = '0;
    upd       = 1'b0;
    wr_reg    = 1'b0;
    clr_all   = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_CLR: clr_all = 1'b1;
      OP_LDI: begin wr_reg = 1'b1; wr_val = imm;      end
      OP_MOV: begin wr_reg = 1'b1; wr_val = result_q; end
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        upd = 1'b1; alu_res = ext[DATA_W-1:0]; alu_flags = nzc(alu_res, ext[DATA_W]);
      end
      OP_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        upd = 1'b1; alu_res = ext[DATA_W-1:0]; alu_flags = nzc(alu_res, ext[DATA_W]);
      end
      OP_XOR: begin upd = 1'b1; alu_res = a ^ b; alu_flags = nzc(alu_res, 1'b0); end
      OP_AND: begin upd = 1'b1; alu_res = a & b; alu_flags = nzc(alu_res, 1'b0); end
      OP_SHR: begin upd = 1'b1; alu_res = a >> 1; alu_flags = nzc(alu_res, a[0]); end
      OP_SHL: begin upd = 1'b1; alu_res = a << 1; alu_flags = nzc(alu_res, a[DATA_W-1]); end
      OP_CMP: begin
        // The extended difference gives N from its MSB and the borrow (a<b) from its top bit.
        ext = {1'b0, a} - {1'b0, b};
        upd = 1'b1; alu_flags = {ext[DATA_W-1], ext[DATA_W], a == b};
      end
      OP_MUL: ;
      default: illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: the register file is a handful of flops that must read zero after reset, so it is reset like any other state.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          mcand  <= {{DATA_W{1'b0}}, a};
          mplier <= b;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          done_q    <= 1'b1;
          illegal_q <= illegal;
          if (clr_all) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            result_q <= '0;
            flags_q  <= '0;
          end else begin
            if (wr_reg) regs[rd] <= wr_val;
            if (upd) begin
              result_q <= alu_res;
              flags_q  <= alu_flags;
            end
          end
        end
      end else if (state == ST_MUL) begin
        // One multiplier bit per edge; the DATA_W-th edge commits the finished product.
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          result_q <= acc_nxt[DATA_W-1:0];
          flags_q  <= nzc(acc_nxt[DATA_W-1:0], |acc_nxt[2*DATA_W-1:DATA_W]);
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign Result    = result_q;
  assign Flags     = flags_q;
  assign Done      = done_q;
  assign IllegalOp = illegal_q;
  assign DbgData   = regs[DbgSel];

endmodule

// File: tb/tb_tiny_cpu_param.sv
// tb_tiny_cpu_param: directed and randomized instruction stream checked against an
// arithmetic reference model of the register file, Result and {N,C,Z} flags.
module tb_tiny_cpu_param;

  localparam int DATA_W  = 8;
  localparam int NREG    = 4;
  localparam int RA_W    = 2;
  localparam int INSTR_W = 4 + 2*RA_W + DATA_W;
  localparam int MASK    = (1 << DATA_W) - 1;

  logic               Clk = 1'b0;
  logic               Reset;
  logic [INSTR_W-1:0] In;
  logic               InValid;
  logic               InReady;
  logic [DATA_W-1:0]  Result;
  logic [2:0]         Flags;
  logic               Done;
  logic               IllegalOp;
  logic [RA_W-1:0]    DbgSel;
  logic [DATA_W-1:0]  DbgData;

  tiny_cpu_param #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .Clk(Clk), .Reset(Reset), .In(In), .InValid(InValid), .InReady(InReady),
    .Result(Result), .Flags(Flags), .Done(Done), .IllegalOp(IllegalOp),
    .DbgSel(DbgSel), .DbgData(DbgData)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int m_regs [NREG];
  int m_res;
  int m_flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) m_regs[i] = 0;
    m_res   = 0;
    m_flags = 0;
  endfunction

  function automatic void model_set(input int res, input int c);
    int n, z;
    m_res   = res & MASK;
    n       = (m_res >> (DATA_W - 1)) & 1;
    z       = (m_res == 0) ? 1 : 0;
    m_flags = (n << 2) | (c << 1) | z;
  endfunction

  // Returns 1 when the opcode is undefined.
  function automatic bit model_exec(input int op, input int rd, input int rs, input int imm);
    int a, b, p, n, c, z;
    a = m_regs[rd];
    b = m_regs[rs];
    case (op)
      0:  model_clear();
      1:  m_regs[rd] = imm;
      2:  m_regs[rd] = m_res;
      3:  model_set(a + b, (a + b > MASK) ? 1 : 0);
      4:  model_set(a - b, (a < b) ? 1 : 0);
      5:  model_set(a ^ b, 0);
      6:  model_set(a & b, 0);
      7:  model_set(a / 2, a % 2);
      8:  model_set(a * 2, (a * 2 > MASK) ? 1 : 0);
      9: begin
        n = (((a - b) & MASK) >> (DATA_W - 1)) & 1;
        c = (a < b) ? 1 : 0;
        z = (a == b) ? 1 : 0;
        m_flags = (n << 2) | (c << 1) | z;
      end
      10: begin
        p = a * b;
        model_set(p, ((p >> DATA_W) != 0) ? 1 : 0);
      end
      default: return 1'b1;
    endcase
    return 1'b0;
  endfunction

  task automatic check_state(input string tag);
    check($sformatf("%s_result", tag), Result, m_res);
    check($sformatf("%s_flags", tag), Flags, m_flags);
    for (int i = 0; i < NREG; i++) begin
      DbgSel = i[RA_W-1:0];
      #1;
      check($sformatf("%s_r%0d", tag, i), DbgData, m_regs[i]);
    end
  endtask

  // Called away from the clock edge with the DUT idle; returns the same way.
  task automatic run_instr(input int op, input int rd, input int rs, input int imm);
    bit exp_ill;
    int edges, low;
    check("in_ready", InReady, 1);
    In      = {op[3:0], rd[RA_W-1:0], rs[RA_W-1:0], imm[DATA_W-1:0]};
    InValid = 1'b1;
    @(posedge Clk); #1;
    exp_ill = model_exec(op, rd, rs, imm);
    if (op == 10) begin
      check("mul_done_early", Done, 0);
      edges = 0;
      low   = 0;
      while (!Done && edges < 20) begin
        if (!InReady) low++;
        In = INSTR_W'($urandom);
        @(posedge Clk); #1;
        edges++;
      end
      InValid = 1'b0;
      check("mul_latency", edges, DATA_W);
      check("mul_ready_low", low, DATA_W);
      check("mul_ready_back", InReady, 1);
    end else begin
      InValid = 1'b0;
    end
    check("done", Done, 1);
    check("illegal", IllegalOp, exp_ill);
    check_state($sformatf("op%0d", op));
    @(posedge Clk); #1;
    check("done_single", Done, 0);
  endtask

  initial begin
    bit saw_done;
    int op, rd, rs, imm;

    Reset   = 1'b1;
    InValid = 1'b0;
    In      = '0;
    DbgSel  = '0;
    model_clear();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_done", Done, 0);
    check("rst_illegal", IllegalOp, 0);
    check_state("rst");
    Reset = 1'b0;
    #1;
    check("rst_ready", InReady, 1);

    run_instr(1, 0, 0, 8'h07);
    run_instr(1, 1, 0, 8'h08);
    run_instr(3, 0, 1, 0);
    check("add_const", Result, 8'h0F);
    check("add_flags_const", Flags, 3'b000);
    run_instr(5, 0, 1, 0);
    check("xor_const", Result, 8'h0F);
    run_instr(9, 0, 1, 0);
    check("cmp_result_kept", Result, 8'h0F);
    check("cmp_flags_const", Flags, 3'b110);
    run_instr(7, 0, 0, 0);
    check("shr_const", Result, 8'h03);
    check("shr_c_const", Flags[1], 1);
    run_instr(2, 1, 0, 0);
    DbgSel = 2'd1; #1;
    check("mov_dbg_const", DbgData, 8'h03);
    run_instr(1, 2, 0, 8'hFF);
    run_instr(1, 3, 0, 8'h01);
    run_instr(3, 2, 3, 0);
    check("add_wrap_const", Result, 8'h00);
    check("add_wrap_flags", Flags, 3'b011);
    run_instr(4, 3, 2, 0);
    check("sub_borrow_const", Result, 8'h02);
    check("sub_borrow_c", Flags[1], 1);
    run_instr(1, 0, 0, 8'h10);
    run_instr(1, 1, 0, 8'h11);
    run_instr(10, 0, 1, 0);
    check("mul_const", Result, 8'h10);
    check("mul_c_const", Flags[1], 1);
    run_instr(10, 1, 1, 0);

    // Reset three cycles into a multiply: no commit, no Done.
    run_instr(1, 0, 0, 8'h23);
    run_instr(1, 1, 0, 8'h45);
    In      = {4'hA, 2'd0, 2'd1, 8'h00};
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    model_clear();
    check("abort_done", Done, 0);
    check_state("abort");
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    check("abort_ready", InReady, 1);
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (Done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check_state("abort_after");

    run_instr(1, 2, 0, 8'h5A);
    run_instr(3, 2, 2, 0);
    run_instr(15, 1, 2, 8'h33);
    run_instr(0, 0, 0, 0);
    check("clr_result_const", Result, 8'h00);

    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 15);
      if (op == 0 && $urandom_range(0, 9) != 0) op = 1;
      rd = $urandom_range(0, NREG - 1);
      rs = $urandom_range(0, NREG - 1);
      case ($urandom_range(0, 5))
        0:       imm = 0;
        1:       imm = MASK;
        2:       imm = 1 << (DATA_W - 1);
        default: imm = $urandom_range(0, MASK);
      endcase
      run_instr(op, rd, rs, imm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
